lfsr_decrypt: RTL
=================

LFSR_DECRYPT -- requirements
Module: lfsr_decrypt

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port init  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port req  input  1  request level; high holds block idle, low launches a run.
REQ-004 SHALL have port ack  output  1  program run complete.
REQ-005 SHALL have port mem_addr  output  8  data-memory address; read data combinational (same cycle).
REQ-006 SHALL have port mem_rd_data  input  8  data-memory read data.
REQ-007 SHALL have port mem_wr_en  output  1  memory write strobe; write occurs at rising edge.
REQ-008 SHALL have port mem_wr_data  output  8  memory write data.
REQ-009 SHALL have ports pat_idx (output, 4 bits) = selected tap index; pre_len (output, 7 bits) = stripped leading-space count; err (output, 1 bit) = no valid pattern found.

Function
REQ-010 SHALL hold a constant tap table, index 0..8: 0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B.
REQ-011 SHALL treat mem[64+i], i=0..63, as ciphertext c[i] = (p[i]-0x20) ^ s[i] (7 bits, bit7=0), with s[i+1] = {s[i][5:0], ^(s[i] & taps)}.
REQ-012 SHALL use the fact that preamble >= 10 spaces, so c[0..9] = s[0..9].
REQ-013 SHALL implement FSM states IDLE, LOAD, SEARCH, DECRYPT, PAD, DONE.
REQ-014 IDLE: mem_wr_en=0, ack=0; -> LOAD on first cycle with req=0.
REQ-015 LOAD: 10 cycles, mem_addr=64..73, capture c[0..9] (bits 6:0) into a 10-entry register file; -> SEARCH.
REQ-016 SEARCH: one candidate per cycle, index 0 upward; candidate matches iff all 9 transitions c[k]->c[k+1], k=0..8, satisfy REQ-011; lowest matching index is selected into pat_idx; -> DECRYPT.
REQ-017 SEARCH SHALL set err=1 and go -> DONE with no memory writes if no candidate matches after index 8 or if c[0]=0 (illegal state).
REQ-018 DECRYPT: 64 cycles, i=0..63, mem_addr=64+i during the read, LFSR regenerated from s[0]=c[0] with selected taps, d[i]=(c[i]^s[i])&0x7F.
REQ-019 While in strip mode and d[i]=0: pre_len increments, no write; first d[i]!=0 ends strip mode.
REQ-020 Outside strip mode: write d[i] to address wptr (starting at 0); wptr increments; read and write of one byte share a cycle via mem_addr muxing over two phases, or two cycles per byte — either permitted; total DECRYPT <= 128 cycles.
REQ-021 PAD: write 0x00 to addresses wptr..63, one per cycle; skipped if wptr=64.
REQ-022 If all 64 d[i]=0: pre_len=64, PAD writes 0x00 to 0..63.
REQ-023 DONE: ack=1, outputs pat_idx/pre_len/err held stable; -> IDLE when req=1; ack drops the cycle after req=1 is sampled.
REQ-024 mem_wr_en SHALL be high only in DECRYPT (non-strip) and PAD.
REQ-025 A run SHALL never write addresses >= 64.

Reset
REQ-026 init=1 SHALL, at the next rising edge, force state=IDLE, ack=0, mem_wr_en=0, err=0, pat_idx=0, pre_len=0, wptr=0, regardless of current state.
REQ-027 Reset mid-run SHALL abort; partially written memory is not restored; the next run (req low after init low) SHALL fully rewrite outputs.
REQ-028 init SHALL take priority over req.

Verification
REQ-029 taps 0x7B, s0=0x01, pre 10, msg "A joke is a very serious thing." -> pat_idx=8, pre_len=10, err=0, mem[0..30]=msg-0x20, mem[31..63]=0x00, ack=1.
REQ-030 taps 0x60, s0=0x7F, pre 26, msg "Mr. Watson" -> pat_idx=0, pre_len=26, mem[0..9]=msg-0x20, mem[10..63]=0x00.
REQ-031 REQ-029 ciphertext with c[5] bit0 flipped -> err=1, ack=1, mem_wr_en never asserted.
REQ-032 all ciphertext 0x00 -> err=1, no writes.
REQ-033 init pulsed during DECRYPT at i=20 -> next cycle ack=0, mem_wr_en=0; rerun reproduces REQ-029 results.
REQ-034 req held high 200 cycles after reset -> no memory access, ack=0; REQ-029 run then req=1 -> ack low one cycle later.

Source files
------------

// File: rtl/lfsr_decrypt.sv
// rtl/lfsr_decrypt.sv - LFSR stream-cipher tap search and decrypt engine
module lfsr_decrypt (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] pat_idx,
    output logic [6:0] pre_len,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, PAD, DONE} state_t;

    state_t      state, state_nxt;
    logic [6:0]  cfile [10];
    logic [3:0]  load_cnt;
    logic [3:0]  cand;
    logic [5:0]  byte_idx;
    logic        phase;
    logic        strip;
    logic        cand_match;
    logic [6:0]  lfsr;
    logic [6:0]  dbuf;
    logic [6:0]  wptr;
    logic        unused_rd_msb;

    assign unused_rd_msb = mem_rd_data[7];

    function automatic logic [6:0] tap_of(input logic [3:0] k);
        case (k)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        lfsr_step = {s[5:0], ^(s & t)};
    endfunction

    // The first ten ciphertext bytes are raw keystream, so a tap set is valid
    // iff it reproduces every captured transition.
    always_comb begin
        cand_match = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (lfsr_step(cfile[k], tap_of(cand)) != cfile[k+1]) cand_match = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (init) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        ack         = 1'b0;
        case (state)
            IDLE: if (!req) state_nxt = LOAD;
            LOAD: begin
                mem_addr = 8'd64 + {4'd0, load_cnt};
                if (load_cnt == 4'd9) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (cfile[0] == 7'd0 || (!cand_match && cand == 4'd8)) state_nxt = DONE;
                else if (cand_match)                                   state_nxt = DECRYPT;
            end
            DECRYPT: begin
                // Phase 0 reads ciphertext byte i, phase 1 writes the plaintext.
                if (!phase) begin
                    mem_addr = 8'd64 + {2'd0, byte_idx};
                end else begin
                    mem_addr = {1'b0, wptr};
                    if (!(strip && dbuf == 7'd0)) begin
                        mem_wr_en   = 1'b1;
                        mem_wr_data = {1'b0, dbuf};
                    end
                    if (byte_idx == 6'd63) state_nxt = PAD;
                end
            end
            PAD: begin
                mem_addr = {1'b0, wptr};
                if (wptr != 7'd64) mem_wr_en = 1'b1;
                if (wptr >= 7'd63) state_nxt = DONE;
            end
            DONE: begin
                ack = 1'b1;
                if (req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) cfile[load_cnt] <= mem_rd_data[6:0];
    end

    always_ff @(posedge clk) begin
        if (init) begin
            pat_idx  <= 4'd0;
            pre_len  <= 7'd0;
            err      <= 1'b0;
            wptr     <= 7'd0;
            load_cnt <= 4'd0;
            cand     <= 4'd0;
            byte_idx <= 6'd0;
            phase    <= 1'b0;
            strip    <= 1'b1;
            lfsr     <= 7'd0;
            dbuf     <= 7'd0;
        end else begin
            case (state)
                IDLE: if (!req) begin
                    pat_idx  <= 4'd0;
                    pre_len  <= 7'd0;
                    err      <= 1'b0;
                    wptr     <= 7'd0;
                    load_cnt <= 4'd0;
                    cand     <= 4'd0;
                    byte_idx <= 6'd0;
                    phase    <= 1'b0;
                    strip    <= 1'b1;
                end
                LOAD: load_cnt <= load_cnt + 4'd1;
                SEARCH: begin
                    if (cfile[0] == 7'd0) begin
                        err <= 1'b1;
                    end else if (cand_match) begin
                        pat_idx <= cand;
                        lfsr    <= cfile[0];
                    end else if (cand == 4'd8) begin
                        err <= 1'b1;
                    end else begin
                        cand <= cand + 4'd1;
                    end
                end
                DECRYPT: begin
                    if (!phase) begin
                        dbuf  <= mem_rd_data[6:0] ^ lfsr;
                        lfsr  <= lfsr_step(lfsr, tap_of(pat_idx));
                        phase <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        byte_idx <= byte_idx + 6'd1;
                        if (strip && dbuf == 7'd0) begin
                            pre_len <= pre_len + 7'd1;
                        end else begin
                            strip <= 1'b0;
                            wptr  <= wptr + 7'd1;
                        end
                    end
                end
                PAD: if (wptr != 7'd64) wptr <= wptr + 7'd1;
                default: ;
            endcase
        end
    end
endmodule
